inst_encoder: RTL and testbench

Packs decoded instruction fields (format, opcode, registers, funct, 32-bit immediate) into RV32I instruction words. It performs the inverse of the immediate decode path: immediates are scattered into the I/S/B/U/J bit positions. A LI pseudo-op expands into ADDI or LUI+ADDI. It sits between the test/boot loader and the instruction-memory write port, with valid/ready handshakes on both sides.

---
 rtl/inst_encoder.sv | 162 ++++++++++++++++
 tb/tb_inst_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into instruction words; LI expands to ADDI or LUI+ADDI.
// Optional immediate range checking is enabled by defining INST_ENC_RANGE_CHECK_EN.
module inst_encoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_last,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    localparam logic [6:0] OpImm = 7'h13;
    localparam logic [6:0] OpLui = 7'h37;

    state_e                r_state, w_state_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic [31:0]           r_out_inst, w_out_inst_nxt;
    logic                  r_out_last, w_out_last_nxt;
    logic [31:0]           r_stage, w_stage_nxt;
    logic                  r_err, w_err_nxt;
    logic [ERR_CNT_W-1:0]  r_err_count, w_err_count_nxt;

    logic        w_accept;
    logic [31:0] w_word0, w_word1;
    logic        w_two;
    logic        w_reject;
    logic [31:0] w_imm_rnd;
    logic        w_li_small;
    logic        w_bad_is, w_bad_b, w_bad_j, w_bad_u;

    assign in_ready   = !rst && (r_state == StIdle) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_imm_rnd  = in_imm + 32'h0000_0800;
    assign w_li_small = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);

`ifdef INST_ENC_RANGE_CHECK_EN
    assign w_bad_is = !w_li_small;
    assign w_bad_b  = !((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) || in_imm[0];
    assign w_bad_j  = !((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) || in_imm[0];
    assign w_bad_u  = (in_imm[11:0] != 12'h000);
`else
    assign w_bad_is = 1'b0;
    assign w_bad_b  = 1'b0;
    assign w_bad_j  = 1'b0;
    assign w_bad_u  = 1'b0;
`endif

    always_comb begin
        w_word0  = '0;
        w_word1  = '0;
        w_two    = 1'b0;
        w_reject = 1'b0;
        case (in_fmt)
            3'd0: w_word0 = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                w_word0  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_reject = w_bad_is;
            end
            3'd2: begin
                w_word0  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_reject = w_bad_is;
            end
            3'd3: begin
                w_word0  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                w_reject = w_bad_b;
            end
            3'd4: begin
                w_word0  = {in_imm[31:12], in_rd, in_opcode};
                w_reject = w_bad_u;
            end
            3'd5: begin
                w_word0  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_reject = w_bad_j;
            end
            3'd6: begin
                if (w_li_small) begin
                    w_word0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, OpImm};
                end else begin
                    // Rounded upper part compensates for the sign-extended ADDI low part.
                    w_word0 = {w_imm_rnd[31:12], in_rd, OpLui};
                    w_word1 = {in_imm[11:0], in_rd, 3'b000, in_rd, OpImm};
                    w_two   = (in_imm[11:0] != 12'h000);
                end
            end
            default: w_reject = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_out_inst_nxt  = r_out_inst;
        w_out_last_nxt  = r_out_last;
        w_stage_nxt     = r_stage;
        w_err_nxt       = w_accept && w_reject;
        w_err_count_nxt = r_err_count;

        if (w_accept && w_reject && !(&r_err_count)) begin
            w_err_count_nxt = r_err_count + 1'b1;
        end

        if (w_accept && !w_reject) begin
            w_out_valid_nxt = 1'b1;
            w_out_inst_nxt  = w_word0;
            w_out_last_nxt  = !w_two;
            if (w_two) begin
                w_stage_nxt = w_word1;
                w_state_nxt = StPend;
            end
        end else if (r_state == StPend && out_ready) begin
            w_out_inst_nxt = r_stage;
            w_out_last_nxt = 1'b1;
            w_state_nxt    = StIdle;
        end else if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_last  <= 1'b0;
            r_stage     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_inst  <= w_out_inst_nxt;
            r_out_last  <= w_out_last_nxt;
            r_stage     <= w_stage_nxt;
            r_err       <= w_err_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_last  = r_out_last;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder; expectations follow INST_ENC_RANGE_CHECK_EN.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ERR_CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_last  (out_last),
        .err       (err),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Presents one request from a falling edge and holds it until accepted.
    task automatic issue(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        @(negedge clk);
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        check({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] inst, input logic last);
        @(negedge clk);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".inst"}, out_inst, inst);
        check({tag, ".last"}, 32'(out_last), 32'(last));
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, ".idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.inst", out_inst, 32'd0);
        check("rst.last", 32'(out_last), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.cnt", 32'(err_count), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1 check("post_rst.ready", 32'(in_ready), 32'd1);

        // Field encodings per format
        issue("itype", 3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        expect_out("itype", 32'hFFF0_0293, 1'b1);
        issue("btype", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        expect_out("btype", 32'h0020_8463, 1'b1);
        issue("stype", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
        expect_out("stype", 32'hFE20_AE23, 1'b1);
        issue("utype", 3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
        expect_out("utype", 32'hABCD_E1B7, 1'b1);
        issue("jtype", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_out("jtype", 32'h0010_00EF, 1'b1);
        expect_idle("jtype");

        // LI expansion: pair, single LUI, single ADDI
        issue("li_pair", 3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        expect_out("li_lui", 32'h1234_60B7, 1'b0);
        expect_out("li_addi", 32'hFFF0_8093, 1'b1);
        expect_idle("li_pair");
        issue("li_lui_only", 3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_0000);
        expect_out("li_lui_only", 32'h0001_00B7, 1'b1);
        issue("li_small", 3'd6, 7'h00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        expect_out("li_small", 32'h8000_0113, 1'b1);

        // Back-to-back R-type at one word per cycle
        @(negedge clk);
        in_fmt = 3'd0; in_opcode = 7'h33; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd3;
        in_funct3 = 3'd0; in_funct7 = 7'h20; in_valid = 1'b1;
        @(posedge clk);
        #1 in_rd = 5'd4; in_rs1 = 5'd5; in_rs2 = 5'd6; in_funct7 = 7'h00;
        @(negedge clk);
        check("b2b.ready", 32'(in_ready), 32'd1);
        check("b2b.first", out_inst, 32'h4031_00B3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("b2b.second", out_inst, 32'h0062_8233);
        check("b2b.valid", 32'(out_valid), 32'd1);
        expect_idle("b2b");

        // Reserved format is rejected
        issue("rsvd", 3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        check("rsvd.err", 32'(err), 32'd1);
        check("rsvd.cnt", 32'(err_count), 32'd1);
        check("rsvd.valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rsvd.err_low", 32'(err), 32'd0);

        // I-type immediate one past the signed 12-bit range
        issue("i2048", 3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
`ifdef INST_ENC_RANGE_CHECK_EN
        @(negedge clk);
        check("i2048.err", 32'(err), 32'd1);
        check("i2048.cnt", 32'(err_count), 32'd2);
        check("i2048.valid", 32'(out_valid), 32'd0);
`else
        expect_out("i2048", 32'h8000_0293, 1'b1);
        check("i2048.err", 32'(err), 32'd0);
        check("i2048.cnt", 32'(err_count), 32'd1);
`endif
        expect_idle("i2048");

        // Backpressure across an LI pair
        out_ready = 1'b0;
        issue("bp", 3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.valid", 32'(out_valid), 32'd1);
            check("bp.inst", out_inst, 32'h1234_60B7);
            check("bp.last", 32'(out_last), 32'd0);
            check("bp.ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        expect_out("bp_addi", 32'hFFF0_8093, 1'b1);
        expect_idle("bp");

        // Reset while the ADDI is staged
        out_ready = 1'b0;
        issue("rp", 3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        @(negedge clk);
        check("rp.pend_inst", out_inst, 32'h1234_60B7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rp.valid", 32'(out_valid), 32'd0);
        check("rp.cnt", 32'(err_count), 32'd0);
        check("rp.ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rp.no_addi", 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
